// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  // Default vector geometry: 16 lanes of 32 bits.
  localparam int VEC_LANES = 16;
  localparam int LANE_DW   = 32;

  typedef logic [LANE_DW-1:0]  lane_t;
  typedef lane_t [VEC_LANES-1:0] vec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOCK  = 2'd2
  } wb_state_t;

  // Requester IDs as seen on grant_id.
  localparam logic [1:0] REQ_SALU = 2'd0;
  localparam logic [1:0] REQ_VALU = 2'd1;
  localparam logic [1:0] REQ_MEM  = 2'd2;

  // r15 is read-only for scalar writes; vector writes to it are fine.
  localparam logic [3:0] RO_REG = 4'd15;

  function automatic logic is_illegal(input logic vec, input logic [3:0] addr);
    return !vec && (addr == RO_REG);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_picker.sv
// Round-robin picker: first requester after ptr (mod N) wins, one-hot grant.
// Latency: combinational.
// Backpressure: none; grant is zero when req is zero.
// Ports: req (request vector), ptr (last winner), gnt (one-hot grant).
module rr_picker #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    // Search starts one past the previous winner so it gets lowest priority.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NREQ write requesters onto a single register-file write port.
// Latency: one cycle from accepted transfer to we3/ra3/wd3.
// Backpressure: req_ready is the grant; wb_hold or reset withholds all grants.
// Ports: req_* (per-requester valid/ready/addr/vec/lock/data), wb_hold,
//        we3/ra3/wd3/selec_v_s_w/grant_id (write port), err_illegal (sticky).
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int LANES = VEC_LANES,
  parameter int DW    = LANE_DW
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ-1:0][3:0]                req_addr,
  input  logic [NREQ-1:0]                     req_vec,
  input  logic [NREQ-1:0]                     req_lock,
  input  logic [NREQ-1:0][LANES-1:0][DW-1:0]  req_data,
  input  logic                                wb_hold,
  output logic                                we3,
  output logic [3:0]                          ra3,
  output logic [LANES-1:0][DW-1:0]            wd3,
  output logic                                selec_v_s_w,
  output logic [1:0]                          grant_id,
  output logic                                err_illegal
);

  wb_state_t  state;
  logic [1:0] rr_ptr;
  logic [1:0] owner;

  logic [NREQ-1:0] owner_mask;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] pick;

  logic                      xfer;
  logic [1:0]                win;
  logic [3:0]                w_addr;
  logic                      w_vec;
  logic                      w_lock;
  logic [LANES-1:0][DW-1:0]  w_data;
  logic                      w_illegal;

  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (2'(i) == owner) owner_mask[i] = 1'b1;
    end
  end

  // During a burst only the owner may compete; the picker then returns it
  // regardless of the pointer.
  assign elig = (state == ST_LOCK) ? (req_valid & owner_mask) : req_valid;

  rr_picker #(
    .N  (NREQ),
    .PW (2)
  ) u_rr_picker (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  assign req_ready = (rst && !wb_hold) ? pick : '0;
  assign xfer      = |req_ready;

  always_comb begin
    win    = '0;
    w_addr = '0;
    w_vec  = 1'b0;
    w_lock = 1'b0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        win    = 2'(i);
        w_addr = req_addr[i];
        w_vec  = req_vec[i];
        w_lock = req_lock[i];
        w_data = req_data[i];
      end
    end
  end

  assign w_illegal = is_illegal(w_vec, w_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= 2'(NREQ - 1);
      owner       <= '0;
      we3         <= 1'b0;
      ra3         <= '0;
      wd3         <= '0;
      selec_v_s_w <= 1'b0;
      grant_id    <= '0;
      err_illegal <= 1'b0;
    end else if (wb_hold) begin
      // Freeze arbitration state, including burst ownership.
      we3 <= 1'b0;
    end else if (xfer) begin
      // An illegal write is consumed but leaves the write port untouched.
      we3 <= !w_illegal;
      if (w_illegal) begin
        err_illegal <= 1'b1;
      end else begin
        ra3         <= w_addr;
        wd3         <= w_data;
        selec_v_s_w <= w_vec;
        grant_id    <= win;
      end
      if (state != ST_LOCK) rr_ptr <= win;
      if (w_lock) begin
        state <= ST_LOCK;
        owner <= win;
      end else begin
        state <= ST_GRANT;
      end
    end else begin
      we3   <= 1'b0;
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus random traffic.
// Latency: expects writes one cycle after each accepted transfer.
// Backpressure: requesters hold each beat until valid&ready, random gaps and holds.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NREQ  = 3;
  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int WDW   = LANES * DW;

  typedef logic [WDW-1:0] flat_t;

  typedef struct {
    logic [3:0] addr;
    logic       vec;
    logic       lock;
    flat_t      data;
  } beat_t;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic       vec;
    flat_t      data;
    logic [1:0] id;
    logic       err;
  } exp_t;

  logic                               clk;
  logic                               rst;
  logic [NREQ-1:0]                    req_valid;
  logic [NREQ-1:0]                    req_ready;
  logic [NREQ-1:0][3:0]               req_addr;
  logic [NREQ-1:0]                    req_vec;
  logic [NREQ-1:0]                    req_lock;
  logic [NREQ-1:0][LANES-1:0][DW-1:0] req_data;
  logic                               wb_hold;
  logic                               we3;
  logic [3:0]                         ra3;
  logic [LANES-1:0][DW-1:0]           wd3;
  logic                               selec_v_s_w;
  logic [1:0]                         grant_id;
  logic                               err_illegal;

  regfile_wb_arbiter #(.NREQ(NREQ), .LANES(LANES), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_vec     (req_vec),
    .req_lock    (req_lock),
    .req_data    (req_data),
    .wb_hold     (wb_hold),
    .we3         (we3),
    .ra3         (ra3),
    .wd3         (wd3),
    .selec_v_s_w (selec_v_s_w),
    .grant_id    (grant_id),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t           q [NREQ][$];
  exp_t            sb [$];
  logic [NREQ-1:0] fired = '0;
  logic [NREQ-1:0] gap;
  int              checks = 0;
  int              errors = 0;

  // Reference model state: last round-robin winner, burst owner (-1 = none).
  int   m_last;
  int   m_owner;
  logic m_err;

  task automatic chk(input string name, input flat_t act, input flat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic flat_t rnd_data();
    flat_t d;
    for (int l = 0; l < LANES; l++) d[l*DW +: DW] = $urandom;
    return d;
  endfunction

  task automatic push_beat(input int r, input logic [3:0] a, input logic v,
                           input logic l, input flat_t d);
    beat_t b;
    b.addr = a;
    b.vec  = v;
    b.lock = l;
    b.data = d;
    q[r].push_back(b);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (fired[i] && q[i].size() > 0) void'(q[i].pop_front());
      if (q[i].size() > 0 && !gap[i]) begin
        req_valid[i] = 1'b1;
        req_addr[i]  = q[i][0].addr;
        req_vec[i]   = q[i][0].vec;
        req_lock[i]  = q[i][0].lock;
        req_data[i]  = q[i][0].data;
      end else begin
        req_valid[i] = 1'b0;
        req_lock[i]  = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      cycle();
      n++;
    end
    if (!all_empty()) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: beats still queued after %0d cycles, required none", budget);
      for (int i = 0; i < NREQ; i++) q[i].delete();
    end
    repeat (2) cycle();
  endtask

  // Model: decide the grant from the rules, check req_ready, queue the write.
  always @(negedge clk) begin : model_p
    int   win;
    exp_t e;
    logic [NREQ-1:0] exp_rdy;
    e.we   = 1'b0;
    e.addr = '0;
    e.vec  = 1'b0;
    e.data = '0;
    e.id   = '0;
    if (!rst) begin
      chk("ready_in_reset", flat_t'(req_ready), '0);
      m_last  = NREQ - 1;
      m_owner = -1;
      m_err   = 1'b0;
      e.err   = 1'b0;
      sb.push_back(e);
      fired   = '0;
    end else begin
      win = -1;
      if (!wb_hold) begin
        if (m_owner >= 0) begin
          if (req_valid[m_owner]) win = m_owner;
        end else begin
          for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last + k) % NREQ;
            if (win < 0 && req_valid[j]) win = j;
          end
        end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("req_ready", flat_t'(req_ready), flat_t'(exp_rdy));
      if (!wb_hold && win < 0) m_owner = -1;
      if (win >= 0) begin
        if (m_owner < 0) m_last = win;
        m_owner = req_lock[win] ? win : -1;
        if (!req_vec[win] && req_addr[win] == 4'd15) begin
          m_err = 1'b1;
        end else begin
          e.we   = 1'b1;
          e.addr = req_addr[win];
          e.vec  = req_vec[win];
          e.data = flat_t'(req_data[win]);
          e.id   = 2'(win);
        end
      end
      e.err = m_err;
      sb.push_back(e);
      fired = req_valid & req_ready;
    end
  end

  // Monitor: compare the write port against the oldest expectation.
  always @(posedge clk) begin : monitor_p
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!rst) begin
        chk("rst_we3", flat_t'(we3), '0);
        chk("rst_ra3", flat_t'(ra3), '0);
        chk("rst_wd3", flat_t'(wd3), '0);
        chk("rst_sel", flat_t'(selec_v_s_w), '0);
        chk("rst_gid", flat_t'(grant_id), '0);
        chk("rst_err", flat_t'(err_illegal), '0);
      end else begin
        chk("we3", flat_t'(we3), flat_t'(e.we));
        chk("err_illegal", flat_t'(err_illegal), flat_t'(e.err));
        if (e.we) begin
          chk("ra3", flat_t'(ra3), flat_t'(e.addr));
          chk("wd3", flat_t'(wd3), e.data);
          chk("selec_v_s_w", flat_t'(selec_v_s_w), flat_t'(e.vec));
          chk("grant_id", flat_t'(grant_id), flat_t'(e.id));
        end
      end
    end
  end

  initial begin : stim_p
    vec_t lanes;
    int   len;
    rst       = 1'b0;
    wb_hold   = 1'b0;
    gap       = '0;
    req_valid = '0;
    req_addr  = '0;
    req_vec   = '0;
    req_lock  = '0;
    req_data  = '0;
    repeat (3) cycle();
    rst = 1'b1;

    // Three scalar requesters at once: grants 0,1,2, ra3 1,2,3.
    push_beat(0, 4'd1, 1'b0, 1'b0, rnd_data());
    push_beat(1, 4'd2, 1'b0, 1'b0, rnd_data());
    push_beat(2, 4'd3, 1'b0, 1'b0, rnd_data());
    drain(20);

    // Vector burst from requester 2 blocks requester 0 until the last beat.
    for (int b = 0; b < 4; b++) push_beat(2, 4'(4 + b), 1'b1, (b != 3), rnd_data());
    cycle();
    push_beat(0, 4'd8, 1'b0, 1'b0, rnd_data());
    drain(20);

    // Scalar write to r15: accepted, dropped, sticky error.
    push_beat(1, 4'd15, 1'b0, 1'b0, rnd_data());
    push_beat(1, 4'd15, 1'b1, 1'b0, rnd_data());
    drain(20);

    // Hold for three cycles in the middle of a burst.
    for (int b = 0; b < 5; b++) push_beat(0, 4'(9 + b), 1'b1, (b != 4), rnd_data());
    push_beat(1, 4'd3, 1'b1, 1'b0, rnd_data());
    cycle();
    cycle();
    wb_hold = 1'b1;
    repeat (3) cycle();
    wb_hold = 1'b0;
    drain(30);

    // Reset mid-burst, then round-robin restarts at requester 0.
    for (int b = 0; b < 6; b++) push_beat(2, 4'(b), 1'b1, 1'b1, rnd_data());
    repeat (3) cycle();
    rst = 1'b0;
    repeat (2) cycle();
    for (int i = 0; i < NREQ; i++) q[i].delete();
    req_valid = '0;
    req_lock  = '0;
    rst = 1'b1;
    push_beat(1, 4'd5, 1'b0, 1'b0, rnd_data());
    push_beat(2, 4'd6, 1'b0, 1'b0, rnd_data());
    drain(20);

    // Vector write with lane k = k+1.
    for (int k = 0; k < LANES; k++) lanes[k] = lane_t'(k + 1);
    push_beat(0, 4'd2, 1'b1, 1'b0, flat_t'(lanes));
    drain(20);

    // Random traffic with bursts, valid gaps and holds.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            push_beat(i, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      (b != len - 1), rnd_data());
        end
        gap[i] = ($urandom_range(0, 7) == 0);
      end
      wb_hold = ($urandom_range(0, 9) == 0);
      cycle();
    end
    gap     = '0;
    wb_hold = 1'b0;
    drain(300);
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
